// File: rtl/cp_insert.sv
// Transmit-side cyclic prefix insertion: buffers NFFT-sample symbols in a
// ping-pong RAM and replays each one as its last NCP samples followed by all NFFT samples.
module cp_insert #(
    parameter int NFFT = 512,
    parameter int NCP  = 32,
    parameter int DW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    input  logic          di_vld,
    output logic          di_rdy,
    output logic [DW-1:0] do_re,
    output logic [DW-1:0] do_im,
    output logic          do_vld
);

    localparam int AW = $clog2(NFFT);

    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

    logic [2*DW-1:0] mem [0:2*NFFT-1];

    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_addr;
    state_t        state;

    logic wr_en;
    logic wr_last;
    logic rd_en;
    logic rd_last;

    assign di_rdy  = ~full[wr_bank];
    assign wr_en   = di_vld & di_rdy;
    assign wr_last = wr_en && (wr_cnt == AW'(NFFT - 1));
    assign rd_en   = (state != S_IDLE);
    assign rd_last = (state == S_BODY) && (rd_addr == AW'(NFFT - 1));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_bank, wr_cnt}] <= {di_re, di_im};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            if (wr_last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + AW'(1);
            end
        end
    end

    // Set and clear never hit the same bank: writes only target a non-full bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (wr_last)
                full[wr_bank] <= 1'b1;
            if (rd_last)
                full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_bank <= 1'b0;
            rd_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (full[rd_bank]) begin
                        state   <= S_CP;
                        rd_addr <= AW'(NFFT - NCP);
                    end
                end
                S_CP: begin
                    if (rd_addr == AW'(NFFT - 1)) begin
                        state   <= S_BODY;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                S_BODY: begin
                    if (rd_last) begin
                        rd_bank <= ~rd_bank;
                        // Chain straight into the next prefix when the other bank is ready.
                        if (full[~rd_bank]) begin
                            state   <= S_CP;
                            rd_addr <= AW'(NFFT - NCP);
                        end else begin
                            state   <= S_IDLE;
                            rd_addr <= '0;
                        end
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rd_addr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_vld <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
        end else begin
            do_vld <= rd_en;
            if (rd_en)
                {do_re, do_im} <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: a reference queue of expected output samples
// is built from every accepted input and compared against the DUT stream.
module tb_cp_insert;

    localparam int NFFT = 512;
    localparam int NCP  = 32;
    localparam int DW   = 12;
    localparam int SYM  = NFFT + NCP;

    logic          clk;
    logic          rst;
    logic [DW-1:0] di_re;
    logic [DW-1:0] di_im;
    logic          di_vld;
    logic          di_rdy;
    logic [DW-1:0] do_re;
    logic [DW-1:0] do_im;
    logic          do_vld;

    cp_insert #(.NFFT(NFFT), .NCP(NCP), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .di_re  (di_re),
        .di_im  (di_im),
        .di_vld (di_vld),
        .di_rdy (di_rdy),
        .do_re  (do_re),
        .do_im  (do_im),
        .do_vld (do_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [23:0] exp_q[$];
    logic [23:0] sbuf [0:NFFT-1];
    logic [23:0] e;
    int wcnt        = 0;
    int pos         = 0;
    int sym_out_idx = 0;
    int last_done   = 0;
    int vld_cnt     = 0;
    int first_vld   = -1;
    int last_vld    = -1;
    logic prev_vld    = 1'b0;
    logic saw_rdy_low = 1'b0;
    logic chk_lat     = 1'b0;
    logic chk_b2b     = 1'b0;
    logic garb_mode   = 1'b0;
    int garb_cnt      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Everything is sampled mid-cycle, where inputs and registered outputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            pos      = 0;
            prev_vld = 1'b0;
        end else begin
            if (do_vld) begin
                if (exp_q.size() == 0) begin
                    check("spurious_vld", {31'd0, do_vld}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("do_re", {20'd0, do_re}, {20'd0, e[23:12]});
                    check("do_im", {20'd0, do_im}, {20'd0, e[11:0]});
                end
                if (pos == 0) begin
                    if (chk_lat)
                        check("latency", cyc, last_done + 2);
                    if (chk_b2b && sym_out_idx > 0)
                        check("b2b_contiguous", {31'd0, prev_vld}, 32'd1);
                end
                if (garb_mode) begin
                    check("garbage_re", {31'd0, do_re[11:9] == 3'b111}, 32'd0);
                    check("garbage_im", {31'd0, do_im[11:9] == 3'b111}, 32'd0);
                end
                pos++;
                if (pos == SYM) begin
                    pos = 0;
                    sym_out_idx++;
                end
                vld_cnt++;
                if (first_vld < 0)
                    first_vld = cyc;
                last_vld = cyc;
            end else if (pos != 0) begin
                check("readout_gap", {31'd0, do_vld}, 32'd1);
            end
            prev_vld = do_vld;
            if (!di_rdy)
                saw_rdy_low = 1'b1;
            if (di_vld && di_rdy) begin
                sbuf[wcnt] = {di_re, di_im};
                wcnt++;
                if (wcnt == NFFT) begin
                    for (int i = NFFT - NCP; i < NFFT; i++) exp_q.push_back(sbuf[i]);
                    for (int i = 0; i < NFFT; i++) exp_q.push_back(sbuf[i]);
                    wcnt      = 0;
                    last_done = cyc + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample until accepted; garbage is shown while not ready if enabled.
    task automatic send(input logic [11:0] re, input logic [11:0] im);
        int guard;
        guard = 0;
        forever begin
            if (di_rdy) begin
                di_re  = re;
                di_im  = im;
                di_vld = 1'b1;
                tick();
                break;
            end
            di_vld = garb_mode;
            di_re  = 12'hE00 | 12'(garb_cnt & 255);
            di_im  = 12'hF00 | 12'(garb_cnt & 255);
            garb_cnt++;
            tick();
            guard++;
            if (guard > 4000) begin
                check("rdy_timeout", {31'd0, di_rdy}, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        di_vld = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_drain();
        int guard;
        di_vld = 1'b0;
        guard  = 0;
        while (exp_q.size() != 0 || do_vld) begin
            tick();
            guard++;
            if (guard > 5000) begin
                check("drain_timeout", exp_q.size(), 0);
                break;
            end
        end
        repeat (3) tick();
        check("idle_after_drain", {31'd0, do_vld}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_do_vld", {31'd0, do_vld}, 32'd0);
        check("rst_di_rdy", {31'd0, di_rdy}, 32'd1);
        exp_q.delete();
        wcnt = 0;
        pos  = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst    = 1'b1;
        di_re  = '0;
        di_im  = '0;
        di_vld = 1'b0;
        #2;
        check("reset_do_vld", {31'd0, do_vld}, 32'd0);
        check("reset_do_re", {20'd0, do_re}, 32'd0);
        check("reset_do_im", {20'd0, do_im}, 32'd0);
        check("reset_di_rdy", {31'd0, di_rdy}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single symbol ramp with latency check
        chk_lat = 1'b1;
        for (int n = 0; n < NFFT; n++) send(12'(n), 12'(511 - n));
        wait_drain();
        chk_lat = 1'b0;

        // Seven contiguous symbols
        vld_cnt     = 0;
        first_vld   = -1;
        saw_rdy_low = 1'b0;
        chk_b2b     = 1'b1;
        sym_out_idx = 0;
        for (int s = 0; s < 7; s++)
            for (int n = 0; n < NFFT; n++)
                send(12'((s * 64 + n) % 4096), 12'(4095 - ((s * 64 + n) % 4096)));
        wait_drain();
        chk_b2b = 1'b0;
        check("s2_vld_count", vld_cnt, 7 * SYM);
        check("s2_vld_span", last_vld - first_vld + 1, 7 * SYM);
        check("s2_rdy_low", {31'd0, saw_rdy_low}, 32'd1);

        // Input gaps inside a symbol
        chk_lat = 1'b1;
        for (int n = 0; n < NFFT; n++) begin
            send(12'(n), 12'(511 - n));
            if (n < 64 && (n % 2) == 0) idle(1);
            if (n == 300) idle(5);
            if (n == NFFT - 2) idle(3);
        end
        wait_drain();
        chk_lat = 1'b0;

        // Garbage presented while not ready must never be stored
        garb_mode = 1'b1;
        for (int s = 0; s < 3; s++)
            for (int n = 0; n < NFFT; n++) send(12'(s * 512 + n), 12'(511 - n));
        wait_drain();
        garb_mode = 1'b0;
        check("s4_garbage_driven", {31'd0, garb_cnt > 0}, 32'd1);

        // Reset during BODY of symbol 1 with symbol 2 half written
        for (int n = 0; n < NFFT; n++) send(12'(n), 12'(511 - n));
        for (int n = 0; n < NFFT / 2; n++) send(12'(2048 + n), 12'(n));
        check("s5_in_body", {31'd0, pos > NCP}, 32'd1);
        do_reset();
        chk_lat = 1'b1;
        for (int n = 0; n < NFFT; n++) send(12'(1024 + n), 12'(2047 - n));
        wait_drain();
        chk_lat = 1'b0;

        // Second symbol completes while the first is in BODY
        chk_b2b     = 1'b1;
        sym_out_idx = 0;
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < NFFT; n++) send(12'(n), 12'(511 - n));
        wait_drain();
        chk_b2b = 1'b0;
        check("s6_two_symbols", sym_out_idx, 2);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp_insert.md
Name: cp_insert

Overview:
- Transmit-side cyclic prefix insertion; the inverse of the receiver's CP removal (DECP).
- Accepts NFFT-sample time-domain OFDM symbols (IFFT output) as 12-bit I/Q.
- Emits each symbol as its last NCP samples followed by all NFFT samples: 544 samples per symbol at defaults.
- Ping-pong symbol buffer allows a second symbol to be written while the first is read out; `di_rdy` throttles the source.

Parameters:
- NFFT, 512, samples per OFDM symbol (power of 2).
- NCP, 32, cyclic prefix length (must be < NFFT).
- DW, 12, bit width of each I/Q component.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `di_re` input DW: input sample, real part.
- `di_im` input DW: input sample, imaginary part.
- `di_vld` input 1: input sample valid.
- `di_rdy` output 1: block can accept a sample this cycle; a sample transfers when `di_vld` && `di_rdy`.
- `do_re` output DW: output sample, real part.
- `do_im` output DW: output sample, imaginary part.
- `do_vld` output 1: output sample valid; no backpressure on output.

Behaviour:
- **Reset.** `rst` high clears all state immediately.
  - `do_re`, `do_im`, `do_vld` = 0; `di_rdy` = 1.
  - Both bank-full flags = 0; `wr_bank` = `rd_bank` = 0; write and read counters = 0; read FSM = IDLE.
  - A reset mid-symbol or mid-readout discards all buffered data. The first sample accepted after reset is sample 0 of a new symbol.
- **Storage.** 2 banks x NFFT words x 2*DW bits, with synchronous read (1-cycle latency). Sample data passes through unmodified: no arithmetic or rounding.
- **Write side.**
  - `di_rdy` = !full[`wr_bank`], driven from registers.
  - Each transfer writes `wr_bank`[`wr_cnt`] and increments `wr_cnt`.
  - The transfer at `wr_cnt` = NFFT-1 sets full[`wr_bank`], toggles `wr_bank` and clears `wr_cnt`.
  - Gaps in `di_vld` within a symbol are allowed and only stall `wr_cnt`.
  - `di_vld` while `di_rdy` = 0 is ignored, and the data is not written.
- **Read FSM.**
  - IDLE: if full[`rd_bank`], go to CP and set `rd_addr` = NFFT-NCP.
  - CP: issue one read per cycle, `rd_addr`++. After NCP reads (addr NFFT-1), go to BODY with `rd_addr` = 0.
  - BODY: issue one read per cycle. After NFFT reads (addr NFFT-1):
    - clear full[`rd_bank`] and toggle `rd_bank`;
    - if full[new `rd_bank`], go directly to CP with `rd_addr` = NFFT-NCP, so symbols are back-to-back with no gap;
    - otherwise go to IDLE.
- **Output timing.**
  - `do_vld` is the read-issue strobe delayed 1 cycle, aligned with RAM data. `do_re`/`do_im` are registered from RAM output.
  - `do_re`/`do_im` hold their last value when `do_vld` = 0.
- **Latency.** The edge that accepts the last sample of a symbol is edge k (read FSM in IDLE). FSM enters CP at edge k+1. The first CP sample has `do_vld` = 1 from edge k+2.
- **Readout shape.** Each symbol produces exactly NFFT+NCP consecutive `do_vld` cycles, ordered as samples NFFT-NCP..NFFT-1 then 0..NFFT-1.
- **Simultaneous events.**
  - Set of full[x] (write) and clear of full[y] (read) in the same cycle both take effect. x == y cannot occur, because writes only target a non-full bank.
  - A bank freed at edge e is writable from cycle e onward (`di_rdy` = 1).
- **Throughput.**
  - Sustained input rate ≤ NFFT/(NFFT+NCP) samples/cycle.
  - With continuously asserted `di_vld`, `di_rdy` deasserts periodically and output stays continuous after the first symbol.

Test Plan:
1. **Single symbol ramp.** After reset, stream 512 samples with `di_re` = n, `di_im` = 511-n, `di_vld` held high.
   - `do_vld` rises 2 edges after the last accept and stays high exactly 544 cycles.
   - `do_re` = 480..511 then 0..511; `do_im` = 31..0 then 511..0.
   - `do_vld` then returns to 0.
2. **Seven symbols continuous.** 3584 samples with `di_vld` = 1 throughout, symbol s sample n carrying `di_re` = (s*64+n) mod 4096.
   - Exactly 3808 `do_vld` cycles, contiguous with no gap after the first sample.
   - Each symbol's 32 prefix samples equal its last 32 samples.
   - `di_rdy` drops to 0 while both banks are full, and no accepted sample is lost or duplicated.
3. **Input gaps.** Toggle `di_vld` 1-0-1-0 within a symbol.
   - Output is identical to scenario 1; readout starts 2 edges after the 512th accepted sample.
4. **Backpressure ignore.** Drive `di_vld` = 1 with distinct garbage values on the cycles where `di_rdy` = 0.
   - None of the garbage values appears on `do_re`/`do_im`.
5. **Reset mid-operation.** Assert `rst` during the BODY readout of symbol 1 while symbol 2 is half-written.
   - `do_vld` = 0 immediately and `di_rdy` = 1.
   - A fresh symbol written after reset outputs correctly per scenario 1, with no residue from the earlier data.
6. **Back-to-back bank switch.** Symbol 2 completes its write while symbol 1 is in BODY.
   - The last body sample of symbol 1 (`do_re` = 511) is immediately followed next cycle by symbol 2's prefix sample 480.
